div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 RV32M divider used by the execute stage. It serves the execute stage's `div_en` / `div_done` handshake: execute requests a divide and the pipeline stalls while the request is held. The unit returns the quotient or remainder for DIV, DIVU, REM and REMU after a fixed latency, and pulses `div_done` for one cycle.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `div_en`  in  1  request. Held high by execute for as long as the divide instruction occupies E.
- `div_ctrl`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `kill`  in  1  abort. Asserted when the E-stage instruction is flushed.
- `op_a`  in  WIDTH  dividend (forwarded rs1); sampled only on accept.
- `op_b`  in  WIDTH  divisor (forwarded rs2); sampled only on accept.
- `div_result`  out  WIDTH  quotient or remainder; valid while `div_done`=1.
- `div_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in CALC and DONE states.

## Operation
- States: IDLE, CALC, DONE.
- Accept: in IDLE with `div_en`=1 and `kill`=0, the unit latches the operands and `div_ctrl`.
  - For signed ops it latches |op_a| and |op_b|.
  - It latches the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a).
  - It clears the partial remainder and loads the iteration counter with WIDTH-1.
  - Next state is CALC, or DONE for the special cases below.
- CALC, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem - divisor, computed WIDTH+1 bits wide.
  - If the trial is non-negative: rem = trial and quo[0] = 1.
  - The counter decrements. When the counter is 0 the step completes and the unit moves to DONE, applying sign correction to the registered `div_result`.
- Sign correction:
  - DIV: negate the quotient if the quotient sign is set.
  - REM: negate the remainder if the remainder sign is set.
  - DIVU and REMU: no correction.
- Special cases, resolved at accept (IDLE goes directly to DONE):
  - op_b = 0: quotient = all ones; remainder = op_a (all four ops).
  - Signed overflow (DIV or REM with op_a = 0x80000000 and op_b = 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- DONE: `div_done`=1 for exactly one cycle, then the unit returns to IDLE unconditionally. The pipeline advances in this cycle.
  - If the next instruction is also a divide, `div_en` stays high and is accepted on the following IDLE cycle.
  - `div_en` is never re-accepted inside DONE, so one instruction never starts twice.
- `kill` in any state forces IDLE on the next edge and suppresses `div_done`. `kill` has priority over accept and completion.
- `div_result` holds its value after DONE until the next completion.

## Timing
- Reset values: state IDLE; `div_done`=0; `busy`=0; `div_result`=0; counter=0.
- Normal latency: accept edge t. CALC runs for WIDTH cycles and `div_done`=1 in cycle t+WIDTH+1, which is cycle t+33 for WIDTH=32.
  - Execute sees `div_stall` for 33 cycles per divide.
- Special-case latency: `div_done`=1 in cycle t+1.
- `div_done` and `div_result` are registered outputs, with no combinational path from the inputs.
- Reset asserted mid-CALC: the unit goes to IDLE immediately and asynchronously, and no `div_done` is produced.
- `div_en` deasserted mid-CALC without `kill` is a protocol violation. The unit ignores it and completes.

## Structure
- Shared package holds the `div_ctrl` encodings as a typedef enum: DIV_S, DIV_U, REM_S, REM_U. decode, de_reg and div_unit share this enum.
- The state enum is local to div_unit.
- No sub-module. The FSM, counter and the shift/subtract datapath live in `div_unit`; execute instantiates it as `u_div`.

## Test plan
- DIV, op_a=100, op_b=7: `div_done` at accept+33, `div_result`=14. REM on the same operands gives 2.
- Signed: DIV -7/2 → 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). REMU 0xFFFFFFF9/2 → 1.
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF with `div_done` at accept+1. REM 0x1234/0 → 0x1234.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM on the same operands → 0. Both with `div_done` at accept+1.
- Back-to-back: DIV 20/3, then DIVU 9/4 with `div_en` held high across both. Exactly two `div_done` pulses, at accept+33 and at accept+33+1+33, with results 6 and 2.
- Abort: `kill` at accept+10 gives no `div_done` and `busy`=0 next cycle. Separately, `rst` at accept+5 clears all outputs asynchronously; a new divide afterwards completes correctly.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared RV32M divide operation encodings and small decode helpers
package div_unit_pkg;
    typedef enum logic [1:0] {DIV_S = 2'b00, DIV_U = 2'b01, REM_S = 2'b10, REM_U = 2'b11} div_op_e;
    function automatic logic is_signed(div_op_e op);
        return op == DIV_S || op == REM_S;
    endfunction
    function automatic logic is_rem(div_op_e op);
        return op == REM_S || op == REM_U;
    endfunction
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage divide request/response bundle
interface div_unit_if #(parameter int WIDTH = 32);
    import div_unit_pkg::*;
    logic             div_en;
    div_op_e          div_ctrl;
    logic             kill;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] div_result;
    logic             div_done;
    logic             busy;
    modport master (output div_en, div_ctrl, kill, op_a, op_b, input div_result, div_done, busy);
    modport slave  (input div_en, div_ctrl, kill, op_a, op_b, output div_result, div_done, busy);
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle
module div_unit #(parameter int WIDTH = 32) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave d
);
    import div_unit_pkg::*;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    state_e           state;
    div_op_e          op;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg;
    logic [WIDTH:0]   sh, trial;
    logic [WIDTH-1:0] rem_nx, quo_nx, res_nx;
    logic             sgn, sign_a, sign_b, ovf;
    logic [WIDTH-1:0] abs_a, abs_b, spec_res;
    assign d.busy = state != IDLE;
    // quo doubles as the dividend shift register: its MSB feeds the remainder each step
    always_comb begin
        sh     = {rem, quo[WIDTH-1]};
        trial  = sh - {1'b0, dvsr};
        rem_nx = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], ~trial[WIDTH]};
        res_nx = is_rem(op) ? (r_neg ? -rem_nx : rem_nx) : (q_neg ? -quo_nx : quo_nx);
    end
    always_comb begin
        sgn      = is_signed(d.div_ctrl);
        sign_a   = sgn & d.op_a[WIDTH-1];
        sign_b   = sgn & d.op_b[WIDTH-1];
        abs_a    = sign_a ? -d.op_a : d.op_a;
        abs_b    = sign_b ? -d.op_b : d.op_b;
        ovf      = sgn && d.op_a == MIN_NEG && &d.op_b;
        spec_res = is_rem(d.div_ctrl) ? (ovf ? '0 : d.op_a) : (ovf ? MIN_NEG : '1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op           <= DIV_S;
            rem          <= '0;
            quo          <= '0;
            dvsr         <= '0;
            cnt          <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            d.div_done   <= 1'b0;
            d.div_result <= '0;
        end else if (d.kill) begin
            state      <= IDLE;
            d.div_done <= 1'b0;
        end else begin
            d.div_done <= 1'b0;
            case (state)
                IDLE: if (d.div_en) begin
                    op    <= d.div_ctrl;
                    dvsr  <= abs_b;
                    quo   <= abs_a;
                    rem   <= '0;
                    cnt   <= CW'(WIDTH - 1);
                    q_neg <= sign_a ^ sign_b;
                    r_neg <= sign_a;
                    if (d.op_b == '0 || ovf) begin
                        state        <= DONE;
                        d.div_done   <= 1'b1;
                        d.div_result <= spec_res;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state        <= DONE;
                        d.div_done   <= 1'b1;
                        d.div_result <= res_nx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit results, latency, back-to-back, kill and async reset
module tb_div_unit;
    import div_unit_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0, passed = 0, fails = 0, pulses = 0;
    div_unit_if #(.WIDTH(32)) bus ();
    div_unit #(.WIDTH(32)) u_div (.clk(clk), .rst(rst), .d(bus));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.div_done === 1'b1) pulses++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // Latency is counted in cycles with the accept cycle as 0; called just after an edge with the unit idle.
    task automatic run(input string tag, input div_op_e c, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] res);
        int n;
        bus.div_ctrl = c;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.div_en   = 1'b1;
        @(posedge clk); #1;
        bus.op_a = ~a;
        bus.op_b = 32'h0;
        n = 1;
        while (bus.div_done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " result"}, bus.div_result, res);
        bus.div_en = 1'b0;
        @(posedge clk); #1;
        check({tag, " one-cycle pulse"}, {31'b0, bus.div_done}, 32'h0);
        check({tag, " result held"}, bus.div_result, res);
    endtask
    initial begin
        int n, p0;
        bus.div_en   = 1'b0;
        bus.kill     = 1'b0;
        bus.div_ctrl = DIV_S;
        bus.op_a     = 32'h0;
        bus.op_b     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset div_done", {31'b0, bus.div_done}, 32'h0);
        check("reset busy", {31'b0, bus.busy}, 32'h0);
        check("reset div_result", bus.div_result, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        run("DIV 100/7", DIV_S, 32'd100, 32'd7, 33, 32'd14);
        run("REM 100/7", REM_S, 32'd100, 32'd7, 33, 32'd2);
        run("DIV -7/2", DIV_S, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run("REM -7/2", REM_S, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run("REMU fff9/2", REM_U, 32'hFFFF_FFF9, 32'd2, 33, 32'd1);
        run("DIV 7/-2", DIV_S, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
        run("REM 7/-2", REM_S, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);
        run("DIVU max/1", DIV_U, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF);
        run("DIVU min/ones", DIV_U, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);
        run("DIVU 1234/0", DIV_U, 32'h1234, 32'd0, 1, 32'hFFFF_FFFF);
        run("REM 1234/0", REM_S, 32'h1234, 32'd0, 1, 32'h1234);
        run("DIV overflow", DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run("REM overflow", REM_S, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);
        // Back-to-back: div_en stays high through DONE, second op accepted on the next IDLE cycle
        p0 = pulses;
        bus.div_ctrl = DIV_S;
        bus.op_a     = 32'd20;
        bus.op_b     = 32'd3;
        bus.div_en   = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (bus.div_done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b first latency", n, 33);
        check("b2b first result", bus.div_result, 32'd6);
        bus.div_ctrl = DIV_U;
        bus.op_a     = 32'd9;
        bus.op_b     = 32'd4;
        @(posedge clk); #1;
        n++;
        check("b2b no re-accept in DONE", {31'b0, bus.busy}, 32'h0);
        while (bus.div_done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b second latency", n, 67);
        check("b2b second result", bus.div_result, 32'd2);
        bus.div_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b pulse count", pulses - p0, 2);
        // Kill ten cycles after accept
        p0 = pulses;
        bus.div_ctrl = DIV_S;
        bus.op_a     = 32'd100;
        bus.op_b     = 32'd7;
        bus.div_en   = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        check("busy mid-calc", {31'b0, bus.busy}, 32'h1);
        bus.kill = 1'b1;
        @(posedge clk); #1;
        check("kill busy", {31'b0, bus.busy}, 32'h0);
        check("kill div_done", {31'b0, bus.div_done}, 32'h0);
        bus.kill   = 1'b0;
        bus.div_en = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("kill no pulse", pulses - p0, 0);
        check("kill keeps result", bus.div_result, 32'd2);
        // Asynchronous reset five cycles after accept, applied mid-cycle
        p0 = pulses;
        bus.div_en = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst busy", {31'b0, bus.busy}, 32'h0);
        check("rst div_done", {31'b0, bus.div_done}, 32'h0);
        check("rst div_result", bus.div_result, 32'h0);
        bus.div_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst no pulse", pulses - p0, 0);
        run("DIV 20/3 after rst", DIV_S, 32'd20, 32'd3, 33, 32'd6);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
